// File: rtl/floo_pkg.sv
// Shared FlooNoC types used by the multicast fork stage.
package floo_pkg;

  typedef enum logic {McastEager, McastLockStep} mcast_mode_e;

  localparam int unsigned McastMaxOutputs = 256;

  typedef logic [8:0] mcast_popcnt_t;

  function automatic mcast_popcnt_t mcast_popcnt(input logic [McastMaxOutputs-1:0] mask);
    mcast_popcnt_t cnt;
    cnt = '0;
    for (int i = 0; i < McastMaxOutputs; i++) cnt += mcast_popcnt_t'(mask[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/floo_mcast_fork_vc.sv
// One virtual channel of the multicast fork: served tracking, handshake, stall and completion counters.
module floo_mcast_fork_vc
  import floo_pkg::*;
#(
  parameter int unsigned NumOutputs  = 5,
  parameter mcast_mode_e Mode        = McastEager,
  parameter int unsigned StallThresh = 64,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [NumOutputs-1:0] mask_i,
  output logic [NumOutputs-1:0] valid_o,
  input  logic [NumOutputs-1:0] ready_i,
  output logic                  stall_o,
  output logic                  drop_o,
  output logic [CntWidth-1:0]   mcast_cnt_o,
  output logic [CntWidth-1:0]   ucast_cnt_o
);

  logic [NumOutputs-1:0] served_q, served_d, pending, acc;
  logic [NumOutputs-1:0] eager_valid, lock_valid;
  logic                  eager_ready, lock_ready, all_rdy, live, fire, is_mcast;

  assign live = valid_i & ~rst_i;

  always_comb begin
    pending     = mask_i & ~served_q;
    all_rdy     = &(~mask_i | ready_i);
    eager_valid = {NumOutputs{live}} & pending;
    lock_valid  = {NumOutputs{live & all_rdy}} & mask_i;
    valid_o     = (Mode == McastEager) ? eager_valid : lock_valid;
    acc         = valid_o & ready_i;
    eager_ready = live & (&(~pending | acc));
    lock_ready  = live & all_rdy;
    ready_o     = (Mode == McastEager) ? eager_ready : lock_ready;
    // In lock-step, acc only fires alongside ready_o, so served_d stays 0.
    served_d    = ready_o ? '0 : (served_q | acc);
  end

  assign fire     = valid_i & ready_o;
  assign drop_o   = fire & ~|mask_i;
  assign is_mcast = mcast_popcnt(McastMaxOutputs'(mask_i)) >= mcast_popcnt_t'(2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      served_q    <= '0;
      mcast_cnt_o <= '0;
      ucast_cnt_o <= '0;
    end else begin
      served_q <= served_d;
      if (fire && |mask_i) begin
        if (is_mcast) mcast_cnt_o <= mcast_cnt_o + 1'b1;
        else          ucast_cnt_o <= ucast_cnt_o + 1'b1;
      end
    end
  end

  if (StallThresh == 0) begin : gen_no_stall
    assign stall_o = 1'b0;
  end else begin : gen_stall
    localparam int unsigned SW = $clog2(StallThresh + 1);
    localparam logic [SW-1:0] Thr = SW'(StallThresh);
    logic [SW-1:0] stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                     stall_q <= '0;
      else if (valid_i && !ready_o) begin
        if (stall_q != Thr)          stall_q <= stall_q + 1'b1;
      end else                       stall_q <= '0;
    end

    assign stall_o = (stall_q == Thr);
  end

  a_mask_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_i && !ready_o) |=> $stable(mask_i));

  if (Mode == McastEager) begin : gen_chk_eager
    a_no_dup: assert property (@(posedge clk_i) disable iff (rst_i) ~|(acc & served_q));
  end else begin : gen_chk_lock
    a_no_served: assert property (@(posedge clk_i) disable iff (rst_i) served_q == '0);
  end

endmodule

// File: rtl/floo_mcast_fork.sv
// Multicast fork: one tracker per VC, output arrays transposed to [output][vc].
module floo_mcast_fork
  import floo_pkg::*;
#(
  parameter int unsigned NumOutputs      = 5,
  parameter int unsigned NumVirtChannels = 2,
  parameter type         flit_t          = logic,
  parameter mcast_mode_e Mode            = McastEager,
  parameter int unsigned StallThresh     = 64,
  parameter int unsigned CntWidth        = 16
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic  [NumVirtChannels-1:0]                     valid_i,
  output logic  [NumVirtChannels-1:0]                     ready_o,
  input  flit_t [NumVirtChannels-1:0]                     data_i,
  input  logic  [NumVirtChannels-1:0][NumOutputs-1:0]     mask_i,
  output logic  [NumOutputs-1:0][NumVirtChannels-1:0]     valid_o,
  input  logic  [NumOutputs-1:0][NumVirtChannels-1:0]     ready_i,
  output flit_t [NumOutputs-1:0][NumVirtChannels-1:0]     data_o,
  output logic  [NumVirtChannels-1:0]                     stall_o,
  output logic  [NumVirtChannels-1:0]                     drop_o,
  output logic  [NumVirtChannels-1:0][CntWidth-1:0]       mcast_cnt_o,
  output logic  [NumVirtChannels-1:0][CntWidth-1:0]       ucast_cnt_o
);

  logic [NumVirtChannels-1:0][NumOutputs-1:0] vc_valid, vc_ready;

  for (genvar v = 0; v < NumVirtChannels; v++) begin : gen_vc
    for (genvar o = 0; o < NumOutputs; o++) begin : gen_out
      assign vc_ready[v][o] = ready_i[o][v];
      assign valid_o[o][v]  = vc_valid[v][o];
      assign data_o[o][v]   = data_i[v];
    end

    floo_mcast_fork_vc #(
      .NumOutputs (NumOutputs),
      .Mode       (Mode),
      .StallThresh(StallThresh),
      .CntWidth   (CntWidth)
    ) i_vc (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_i[v]),
      .ready_o    (ready_o[v]),
      .mask_i     (mask_i[v]),
      .valid_o    (vc_valid[v]),
      .ready_i    (vc_ready[v]),
      .stall_o    (stall_o[v]),
      .drop_o     (drop_o[v]),
      .mcast_cnt_o(mcast_cnt_o[v]),
      .ucast_cnt_o(ucast_cnt_o[v])
    );
  end

endmodule

// File: tb/tb_floo_mcast_fork.sv
// Directed bench: an eager and a lock-step fork (5 outputs, 2 VCs, thresh 4, 4-bit counters).
module tb_floo_mcast_fork;
  import floo_pkg::*;

  localparam int NO = 5;
  localparam int NV = 2;
  typedef logic [7:0] flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flit_t [NV-1:0]          data = '0;
  logic  [NV-1:0]          e_valid = '0, l_valid = '0;
  logic  [NV-1:0][NO-1:0]  e_mask = '0, l_mask = '0;
  logic  [NO-1:0][NV-1:0]  e_rdy = '0, l_rdy = '0;

  logic  [NV-1:0]          e_ready, l_ready, e_stall, l_stall, e_drop, l_drop;
  logic  [NO-1:0][NV-1:0]  e_vld, l_vld;
  flit_t [NO-1:0][NV-1:0]  e_dat, l_dat;
  logic  [NV-1:0][3:0]     e_mc, e_uc, l_mc, l_uc;

  int total = 0;
  int bad   = 0;

  floo_mcast_fork #(.NumOutputs(NO), .NumVirtChannels(NV), .flit_t(flit_t),
    .Mode(McastEager), .StallThresh(4), .CntWidth(4)) dut_e (
    .clk_i(clk), .rst_i(rst), .valid_i(e_valid), .ready_o(e_ready), .data_i(data),
    .mask_i(e_mask), .valid_o(e_vld), .ready_i(e_rdy), .data_o(e_dat),
    .stall_o(e_stall), .drop_o(e_drop), .mcast_cnt_o(e_mc), .ucast_cnt_o(e_uc));

  floo_mcast_fork #(.NumOutputs(NO), .NumVirtChannels(NV), .flit_t(flit_t),
    .Mode(McastLockStep), .StallThresh(4), .CntWidth(4)) dut_l (
    .clk_i(clk), .rst_i(rst), .valid_i(l_valid), .ready_o(l_ready), .data_i(data),
    .mask_i(l_mask), .valid_o(l_vld), .ready_i(l_rdy), .data_o(l_dat),
    .stall_o(l_stall), .drop_o(l_drop), .mcast_cnt_o(l_mc), .ucast_cnt_o(l_uc));

  function automatic logic [NO-1:0] e_col(input int v);
    logic [NO-1:0] r;
    for (int o = 0; o < NO; o++) r[o] = e_vld[o][v];
    return r;
  endfunction

  function automatic logic [NO-1:0] l_col(input int v);
    logic [NO-1:0] r;
    for (int o = 0; o < NO; o++) r[o] = l_vld[o][v];
    return r;
  endfunction

  task automatic set_e_rdy(input int v, input logic [NO-1:0] r);
    for (int o = 0; o < NO; o++) e_rdy[o][v] = r[o];
  endtask

  task automatic set_l_rdy(input int v, input logic [NO-1:0] r);
    for (int o = 0; o < NO; o++) l_rdy[o][v] = r[o];
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    rst = 1'b1;
    e_valid = 2'b11; l_valid = 2'b11;
    e_mask[0] = 5'b10110; e_mask[1] = 5'b00001;
    l_mask[0] = 5'b10110; l_mask[1] = 5'b00001;
    e_rdy = '1; l_rdy = '1;
    #1;
    total++;
    if ({e_vld, l_vld} !== '0) begin
      bad++; $display("FAIL rst_valid got=%h exp=0", {e_vld, l_vld});
    end
    total++;
    if ({e_ready, l_ready} !== 4'b0) begin
      bad++; $display("FAIL rst_ready got=%b exp=0000", {e_ready, l_ready});
    end
    cyc();
    total++;
    if ({e_mc, e_uc, l_mc, l_uc} !== 32'h0) begin
      bad++; $display("FAIL rst_cnt got=%h exp=0", {e_mc, e_uc, l_mc, l_uc});
    end
    total++;
    if ({e_stall, e_drop, l_stall, l_drop} !== 8'h0) begin
      bad++; $display("FAIL rst_stall_drop got=%b exp=0", {e_stall, e_drop, l_stall, l_drop});
    end
    cyc();
    rst = 1'b0;
    e_valid = '0; l_valid = '0; e_mask = '0; l_mask = '0; e_rdy = '0; l_rdy = '0;
  endtask

  task automatic test_eager_partial();
    cyc();
    data[0] = 8'hA5; e_valid[0] = 1'b1; e_mask[0] = 5'b10110; set_e_rdy(0, 5'b10010);
    #1;
    total++;
    if (e_col(0) !== 5'b10110 || e_ready[0] !== 1'b0) begin
      bad++; $display("FAIL ep_c0 valid=%b ready=%b exp 10110/0", e_col(0), e_ready[0]);
    end
    total++;
    if (e_dat[4][0] !== 8'hA5) begin
      bad++; $display("FAIL ep_data got=%h exp=a5", e_dat[4][0]);
    end
    for (int c = 1; c < 3; c++) begin
      cyc(); set_e_rdy(0, 5'b11011); #1;
      total++;
      if (e_col(0) !== 5'b00100 || e_ready[0] !== 1'b0) begin
        bad++; $display("FAIL ep_c%0d valid=%b ready=%b exp 00100/0", c, e_col(0), e_ready[0]);
      end
    end
    cyc(); set_e_rdy(0, 5'b11111); #1;
    total++;
    if (e_col(0) !== 5'b00100 || e_ready[0] !== 1'b1) begin
      bad++; $display("FAIL ep_c3 valid=%b ready=%b exp 00100/1", e_col(0), e_ready[0]);
    end
    cyc(); e_valid[0] = 1'b0; set_e_rdy(0, '0); #1;
    total++;
    if ({e_mc[0], e_uc[0]} !== {4'd1, 4'd0} || e_col(0) !== '0) begin
      bad++; $display("FAIL ep_cnt mc=%0d uc=%0d valid=%b exp 1/0/00000", e_mc[0], e_uc[0], e_col(0));
    end
  endtask

  task automatic test_eager_single();
    cyc(); e_valid[0] = 1'b1; e_mask[0] = 5'b11000; set_e_rdy(0, 5'b11111); #1;
    total++;
    if (e_col(0) !== 5'b11000 || e_ready[0] !== 1'b1) begin
      bad++; $display("FAIL es_c0 valid=%b ready=%b exp 11000/1", e_col(0), e_ready[0]);
    end
    cyc(); e_mask[0] = 5'b01100; set_e_rdy(0, '0); #1;
    total++;
    if (e_col(0) !== 5'b01100 || e_ready[0] !== 1'b0 || e_mc[0] !== 4'd2) begin
      bad++; $display("FAIL es_c1 valid=%b ready=%b mc=%0d exp 01100/0/2", e_col(0), e_ready[0], e_mc[0]);
    end
    cyc(); set_e_rdy(0, 5'b01100); #1;
    total++;
    if (e_ready[0] !== 1'b1) begin
      bad++; $display("FAIL es_c2 ready=%b exp=1", e_ready[0]);
    end
    cyc(); e_valid[0] = 1'b0; set_e_rdy(0, '0); #1;
    total++;
    if (e_mc[0] !== 4'd3) begin
      bad++; $display("FAIL es_cnt mc=%0d exp=3", e_mc[0]);
    end
  endtask

  task automatic test_lockstep();
    cyc(); l_valid[0] = 1'b1; l_mask[0] = 5'b10110; set_l_rdy(0, 5'b11011);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) cyc();
      #1;
      total++;
      if (l_col(0) !== 5'b00000 || l_ready[0] !== 1'b0) begin
        bad++; $display("FAIL ls_c%0d valid=%b ready=%b exp 00000/0", c, l_col(0), l_ready[0]);
      end
    end
    cyc(); set_l_rdy(0, 5'b11111); #1;
    total++;
    if (l_col(0) !== 5'b10110 || l_ready[0] !== 1'b1) begin
      bad++; $display("FAIL ls_c3 valid=%b ready=%b exp 10110/1", l_col(0), l_ready[0]);
    end
    cyc(); l_valid[0] = 1'b0; set_l_rdy(0, '0); #1;
    total++;
    if ({l_mc[0], l_uc[0]} !== {4'd1, 4'd0}) begin
      bad++; $display("FAIL ls_cnt mc=%0d uc=%0d exp 1/0", l_mc[0], l_uc[0]);
    end
  endtask

  task automatic test_zero_mask();
    cyc();
    e_valid[1] = 1'b1; e_mask[1] = '0; set_e_rdy(1, '0);
    l_valid[1] = 1'b1; l_mask[1] = '0; set_l_rdy(1, '0);
    #1;
    total++;
    if (e_ready[1] !== 1'b1 || e_drop[1] !== 1'b1 || e_col(1) !== '0) begin
      bad++; $display("FAIL zm_eager ready=%b drop=%b valid=%b exp 1/1/00000", e_ready[1], e_drop[1], e_col(1));
    end
    total++;
    if (l_ready[1] !== 1'b1 || l_drop[1] !== 1'b1 || l_col(1) !== '0) begin
      bad++; $display("FAIL zm_lock ready=%b drop=%b valid=%b exp 1/1/00000", l_ready[1], l_drop[1], l_col(1));
    end
    cyc(); e_valid[1] = 1'b0; l_valid[1] = 1'b0; #1;
    total++;
    if (e_drop[1] !== 1'b0 || {e_mc[1], e_uc[1], l_mc[1], l_uc[1]} !== 16'h0) begin
      bad++; $display("FAIL zm_after drop=%b cnt=%h exp 0/0000", e_drop[1], {e_mc[1], e_uc[1], l_mc[1], l_uc[1]});
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 8; c++) begin
      cyc();
      e_valid[0] = (c <= 6); e_mask[0] = 5'b00001; set_e_rdy(0, (c == 6) ? 5'b00001 : 5'b00000);
      #1;
      if (c == 3) begin
        total++;
        if (e_stall[0] !== 1'b0) begin
          bad++; $display("FAIL st_c3 stall=%b exp=0", e_stall[0]);
        end
      end
      if (c == 4) begin
        total++;
        if (e_stall[0] !== 1'b1) begin
          bad++; $display("FAIL st_c4 stall=%b exp=1", e_stall[0]);
        end
      end
      if (c == 6) begin
        total++;
        if (e_stall[0] !== 1'b1 || e_ready[0] !== 1'b1) begin
          bad++; $display("FAIL st_c6 stall=%b ready=%b exp 1/1", e_stall[0], e_ready[0]);
        end
      end
      if (c == 7) begin
        total++;
        if (e_stall[0] !== 1'b0 || e_uc[0] !== 4'd1) begin
          bad++; $display("FAIL st_c7 stall=%b uc=%0d exp 0/1", e_stall[0], e_uc[0]);
        end
      end
    end
    set_e_rdy(0, '0);
  endtask

  task automatic test_reset_mid();
    cyc();
    e_valid = 2'b11; e_mask[0] = 5'b10110; e_mask[1] = 5'b00001;
    set_e_rdy(0, 5'b10010); set_e_rdy(1, 5'b00001);
    #1;
    total++;
    if (e_col(0) !== 5'b10110 || e_ready !== 2'b10) begin
      bad++; $display("FAIL rm_c0 valid=%b ready=%b exp 10110/10", e_col(0), e_ready);
    end
    cyc();
    total++;
    if (e_uc[1] !== 4'd1) begin
      bad++; $display("FAIL rm_pre uc1=%0d exp=1", e_uc[1]);
    end
    rst = 1'b1; #1;
    total++;
    if (e_vld !== '0 || e_ready !== 2'b00 || {e_mc, e_uc} !== 16'h0) begin
      bad++; $display("FAIL rm_in_rst valid=%h ready=%b cnt=%h exp 0/00/0", e_vld, e_ready, {e_mc, e_uc});
    end
    cyc();
    cyc(); rst = 1'b0; set_e_rdy(0, '0); #1;
    total++;
    if (e_col(0) !== 5'b10110 || e_ready !== 2'b10) begin
      bad++; $display("FAIL rm_post valid=%b ready=%b exp 10110/10", e_col(0), e_ready);
    end
    cyc(); set_e_rdy(0, 5'b11111); #1;
    total++;
    if (e_ready !== 2'b11 || e_uc[1] !== 4'd1) begin
      bad++; $display("FAIL rm_c4 ready=%b uc1=%0d exp 11/1", e_ready, e_uc[1]);
    end
    cyc(); e_valid = '0; e_rdy = '0; #1;
    total++;
    if ({e_mc[0], e_uc[0], e_mc[1], e_uc[1]} !== {4'd1, 4'd0, 4'd0, 4'd2}) begin
      bad++; $display("FAIL rm_cnt mc0=%0d uc0=%0d mc1=%0d uc1=%0d exp 1/0/0/2", e_mc[0], e_uc[0], e_mc[1], e_uc[1]);
    end
  endtask

  task automatic test_wrap();
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    e_valid[1] = 1'b1; e_mask[1] = 5'b00010; set_e_rdy(1, 5'b00010);
    for (int i = 0; i < 17; i++) begin
      #1;
      total++;
      if (e_vld[1][1] !== 1'b1 || e_ready[1] !== 1'b1) begin
        bad++; $display("FAIL wr_b2b_%0d valid=%b ready=%b exp 1/1", i, e_vld[1][1], e_ready[1]);
      end
      cyc();
    end
    e_valid[1] = 1'b0; set_e_rdy(1, '0); #1;
    total++;
    if (e_uc[1] !== 4'd1 || e_mc[1] !== 4'd0) begin
      bad++; $display("FAIL wr_cnt uc1=%0d mc1=%0d exp 1/0", e_uc[1], e_mc[1]);
    end
  endtask

  initial begin
    test_reset();
    test_eager_partial();
    test_eager_single();
    test_lockstep();
    test_zero_mask();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
